// File: rtl/seq_chk_pkg.sv
// +------------------------------------------------------------------+
// | seq_chk_pkg : shared types and sizing helpers for the checker     |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

package seq_chk_pkg;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      CHECK = 1'b1
   } state_t;

   localparam int CNT_W = 16;

   // Step index width, never narrower than one bit.
   function automatic int step_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

`default_nettype wire

// File: rtl/seq_chk_lane.sv
// +------------------------------------------------------------------+
// | seq_chk_lane : one "guard throughout sequence" checker channel    |
// | Optional pass/fail counters under SEQ_CHK_COUNT_EN. Rev 1.0       |
// +------------------------------------------------------------------+
`default_nettype none

module seq_chk_lane
   import seq_chk_pkg::*;
#(
   parameter int SEQ_LEN = 2,
   parameter int STEP_W  = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start_i,
   input  logic               guard_i,
   input  logic [SEQ_LEN-1:0] ev_i,
   output logic               busy_o,
   output logic               pass_o,
   output logic               fail_o,
   output logic [STEP_W-1:0]  fail_step_o,
   output logic               fail_guard_o,
`ifdef SEQ_CHK_COUNT_EN
   output logic [CNT_W-1:0]   pass_cnt_o,
   output logic [CNT_W-1:0]   fail_cnt_o,
`endif
   output logic               overlap_o
);

   localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(SEQ_LEN - 1);

   state_t              state_q, state_d;
   logic [STEP_W-1:0]   step_q, step_d;
   logic                pass_q, pass_d;
   logic                fail_q, fail_d;
   logic                overlap_q, overlap_d;
   logic [STEP_W-1:0]   fail_step_q, fail_step_d;
   logic                fail_guard_q, fail_guard_d;

   always_comb begin
      state_d      = state_q;
      step_d       = step_q;
      pass_d       = 1'b0;
      fail_d       = 1'b0;
      overlap_d    = 1'b0;
      fail_step_d  = fail_step_q;
      fail_guard_d = fail_guard_q;
      case (state_q)
         IDLE: begin
            if (start_i) begin
               state_d = CHECK;
               step_d  = '0;
            end
         end
         CHECK: begin
            overlap_d = start_i;
            // Guard is checked first so it wins the cause report.
            if (!guard_i) begin
               fail_d       = 1'b1;
               fail_guard_d = 1'b1;
               fail_step_d  = step_q;
               state_d      = IDLE;
               step_d       = '0;
            end else if (!ev_i[step_q]) begin
               fail_d       = 1'b1;
               fail_guard_d = 1'b0;
               fail_step_d  = step_q;
               state_d      = IDLE;
               step_d       = '0;
            end else if (step_q == LAST_STEP) begin
               pass_d  = 1'b1;
               state_d = IDLE;
               step_d  = '0;
            end else begin
               step_d = step_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            step_d  = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         step_q       <= '0;
         pass_q       <= 1'b0;
         fail_q       <= 1'b0;
         overlap_q    <= 1'b0;
         fail_step_q  <= '0;
         fail_guard_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         step_q       <= step_d;
         pass_q       <= pass_d;
         fail_q       <= fail_d;
         overlap_q    <= overlap_d;
         fail_step_q  <= fail_step_d;
         fail_guard_q <= fail_guard_d;
      end
   end

   assign busy_o       = (state_q == CHECK);
   assign pass_o       = pass_q;
   assign fail_o       = fail_q;
   assign overlap_o    = overlap_q;
   assign fail_step_o  = fail_step_q;
   assign fail_guard_o = fail_guard_q;

`ifdef SEQ_CHK_COUNT_EN
   logic [CNT_W-1:0] pass_cnt_q, pass_cnt_d;
   logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;

   // Counters step on the same edge that raises the pulse and stick at all-ones.
   always_comb begin
      pass_cnt_d = pass_cnt_q;
      fail_cnt_d = fail_cnt_q;
      if (pass_d && (pass_cnt_q != {CNT_W{1'b1}})) pass_cnt_d = pass_cnt_q + 1'b1;
      if (fail_d && (fail_cnt_q != {CNT_W{1'b1}})) fail_cnt_d = fail_cnt_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pass_cnt_q <= '0;
         fail_cnt_q <= '0;
      end else begin
         pass_cnt_q <= pass_cnt_d;
         fail_cnt_q <= fail_cnt_d;
      end
   end

   assign pass_cnt_o = pass_cnt_q;
   assign fail_cnt_o = fail_cnt_q;
`endif

endmodule

`default_nettype wire

// File: rtl/seq_throughout_chk.sv
// +------------------------------------------------------------------+
// | seq_throughout_chk : NUM_CH independent guard-throughout checkers |
// | Optional counters under SEQ_CHK_COUNT_EN. Rev 1.0                 |
// +------------------------------------------------------------------+
`default_nettype none

module seq_throughout_chk
   import seq_chk_pkg::*;
#(
   parameter  int NUM_CH  = 4,
   parameter  int SEQ_LEN = 2,
   localparam int STEP_W  = step_w(SEQ_LEN)
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [NUM_CH-1:0]              start,
   input  logic [NUM_CH-1:0]              guard,
   input  logic [NUM_CH-1:0][SEQ_LEN-1:0] ev,
   output logic [NUM_CH-1:0]              busy,
   output logic [NUM_CH-1:0]              pass,
   output logic [NUM_CH-1:0]              fail,
   output logic [NUM_CH-1:0][STEP_W-1:0]  fail_step,
   output logic [NUM_CH-1:0]              fail_guard,
`ifdef SEQ_CHK_COUNT_EN
   output logic [NUM_CH-1:0][CNT_W-1:0]   pass_cnt,
   output logic [NUM_CH-1:0][CNT_W-1:0]   fail_cnt,
`endif
   output logic [NUM_CH-1:0]              overlap
);

   for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
      seq_chk_lane #(
         .SEQ_LEN (SEQ_LEN),
         .STEP_W  (STEP_W)
      ) u_lane (
         .clk          (clk),
         .rst_n        (rst_n),
         .start_i      (start[c]),
         .guard_i      (guard[c]),
         .ev_i         (ev[c]),
         .busy_o       (busy[c]),
         .pass_o       (pass[c]),
         .fail_o       (fail[c]),
         .fail_step_o  (fail_step[c]),
         .fail_guard_o (fail_guard[c]),
`ifdef SEQ_CHK_COUNT_EN
         .pass_cnt_o   (pass_cnt[c]),
         .fail_cnt_o   (fail_cnt[c]),
`endif
         .overlap_o    (overlap[c])
      );
   end

endmodule

`default_nettype wire

// File: tb/tb_seq_throughout_chk.sv
// Directed self-checking bench for seq_throughout_chk (NUM_CH=5, SEQ_LEN=2).
`default_nettype none

module tb_seq_throughout_chk;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [4:0]      start;
   logic [4:0]      guard;
   logic [4:0][1:0] ev;
   logic [4:0]      busy, pass, fail, fail_guard, overlap;
   logic [4:0][0:0] fail_step;
`ifdef SEQ_CHK_COUNT_EN
   logic [4:0][15:0] pass_cnt, fail_cnt;
`endif

   int ntests = 0;
   int nfail  = 0;

   always #5 clk = ~clk;

   seq_throughout_chk #(.NUM_CH(5), .SEQ_LEN(2)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .guard      (guard),
      .ev         (ev),
      .busy       (busy),
      .pass       (pass),
      .fail       (fail),
      .fail_step  (fail_step),
      .fail_guard (fail_guard),
`ifdef SEQ_CHK_COUNT_EN
      .pass_cnt   (pass_cnt),
      .fail_cnt   (fail_cnt),
`endif
      .overlap    (overlap)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      start = '0;
      guard = '0;
      ev    = '0;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      clear_inputs();
      rst_n = 1'b0;
      #1;
      ntests++;
      if ({busy, pass, fail, fail_guard, overlap, fail_step} !== 30'd0) begin
         nfail++;
         $display("FAIL reset_outputs: got %b want 0", {busy, pass, fail, fail_guard, overlap, fail_step});
      end
      tick();
      rst_n = 1'b1;
      tick();
      ntests++;
      if (busy !== 5'b0) begin
         nfail++;
         $display("FAIL reset_idle_busy: got %b want 00000", busy);
      end
   endtask

   task automatic test_pass();
      do_reset();
      start[0] = 1'b1; guard[0] = 1'b1;
      tick();                                   // edge 1
      ntests++;
      if (busy[0] !== 1'b1) begin nfail++; $display("FAIL pass_busy_e1: got %b want 1", busy[0]); end
      start[0] = 1'b0; ev[0] = 2'b01;
      tick();                                   // edge 2
      ntests++;
      if (busy[0] !== 1'b1 || pass[0] !== 1'b0) begin
         nfail++; $display("FAIL pass_e2: busy=%b pass=%b want busy=1 pass=0", busy[0], pass[0]);
      end
      ev[0] = 2'b10;
      tick();                                   // edge 3
      ntests++;
      if (pass[0] !== 1'b1 || fail[0] !== 1'b0 || busy[0] !== 1'b0) begin
         nfail++; $display("FAIL pass_e3: pass=%b fail=%b busy=%b want 1 0 0", pass[0], fail[0], busy[0]);
      end
      ev[0] = 2'b00;
      tick();                                   // edge 4, guard still high
      ntests++;
      if (pass[0] !== 1'b0 || fail[0] !== 1'b0) begin
         nfail++; $display("FAIL pass_pulse_width: pass=%b fail=%b want 0 0", pass[0], fail[0]);
      end
   endtask

   task automatic test_guard_fail();
      do_reset();
      start[0] = 1'b1;
      tick();                                   // edge 1
      start[0] = 1'b0; guard[0] = 1'b1; ev[0] = 2'b01;
      tick();                                   // edge 2
      guard[0] = 1'b0; ev[0] = 2'b10;
      tick();                                   // edge 3
      ntests++;
      if (fail[0] !== 1'b1 || pass[0] !== 1'b0 || fail_guard[0] !== 1'b1 || fail_step[0] !== 1'b1) begin
         nfail++; $display("FAIL guard_fail: fail=%b pass=%b fg=%b fs=%b want 1 0 1 1",
                           fail[0], pass[0], fail_guard[0], fail_step[0]);
      end
      ev[0] = 2'b00;
      tick();
      ntests++;
      if (fail[0] !== 1'b0 || fail_guard[0] !== 1'b1 || fail_step[0] !== 1'b1) begin
         nfail++; $display("FAIL guard_fail_hold: fail=%b fg=%b fs=%b want 0 1 1",
                           fail[0], fail_guard[0], fail_step[0]);
      end
   endtask

   task automatic test_event_fail();
      do_reset();
      start[0] = 1'b1;
      tick();                                   // edge 1
      start[0] = 1'b0; guard[0] = 1'b1; ev[0] = 2'b01;
      tick();                                   // edge 2
      ev[0] = 2'b00;
      tick();                                   // edge 3
      ntests++;
      if (fail[0] !== 1'b1 || fail_guard[0] !== 1'b0 || fail_step[0] !== 1'b1 || busy[0] !== 1'b0) begin
         nfail++; $display("FAIL event_fail: fail=%b fg=%b fs=%b busy=%b want 1 0 1 0",
                           fail[0], fail_guard[0], fail_step[0], busy[0]);
      end
      ev[0] = 2'b10;
      tick();                                   // late event must not pass
      ntests++;
      if (pass[0] !== 1'b0 || fail[0] !== 1'b0 || busy[0] !== 1'b0) begin
         nfail++; $display("FAIL event_fail_late: pass=%b fail=%b busy=%b want 0 0 0", pass[0], fail[0], busy[0]);
      end
      // Step 0 with both guard and event low: guard reported.
      clear_inputs();
      start[0] = 1'b1;
      tick();
      start[0] = 1'b0;
      tick();
      ntests++;
      if (fail[0] !== 1'b1 || fail_guard[0] !== 1'b1 || fail_step[0] !== 1'b0) begin
         nfail++; $display("FAIL guard_priority_s0: fail=%b fg=%b fs=%b want 1 1 0",
                           fail[0], fail_guard[0], fail_step[0]);
      end
   endtask

   task automatic test_overlap();
      do_reset();
      start[0] = 1'b1; guard[0] = 1'b1;
      tick();                                   // edge 1
      ev[0] = 2'b01;
      tick();                                   // edge 2, start still high
      ntests++;
      if (overlap[0] !== 1'b1 || busy[0] !== 1'b1) begin
         nfail++; $display("FAIL overlap_e2: ovl=%b busy=%b want 1 1", overlap[0], busy[0]);
      end
      start[0] = 1'b0; ev[0] = 2'b10;
      tick();                                   // edge 3
      ntests++;
      if (overlap[0] !== 1'b0 || pass[0] !== 1'b1) begin
         nfail++; $display("FAIL overlap_e3: ovl=%b pass=%b want 0 1", overlap[0], pass[0]);
      end
      ev[0] = 2'b00;
      tick();
      ntests++;
      if (busy[0] !== 1'b0 || pass[0] !== 1'b0 || fail[0] !== 1'b0) begin
         nfail++; $display("FAIL overlap_single: busy=%b pass=%b fail=%b want 0 0 0", busy[0], pass[0], fail[0]);
      end
      // Start on the completing edge: overlap flagged, no new sequence.
      start[0] = 1'b1;
      tick();
      start[0] = 1'b0; ev[0] = 2'b01;
      tick();
      start[0] = 1'b1; ev[0] = 2'b10;
      tick();
      ntests++;
      if (pass[0] !== 1'b1 || overlap[0] !== 1'b1 || busy[0] !== 1'b0) begin
         nfail++; $display("FAIL overlap_complete: pass=%b ovl=%b busy=%b want 1 1 0", pass[0], overlap[0], busy[0]);
      end
      start[0] = 1'b0;
   endtask

   task automatic test_reset_mid();
      do_reset();
      // Leave a prior failure recorded so reset has something to clear.
      start[0] = 1'b1;
      tick();
      start[0] = 1'b0;
      tick();
      start[0] = 1'b1; guard[0] = 1'b1;
      tick();                                   // edge 1
      start[0] = 1'b0; ev[0] = 2'b01;
      tick();                                   // edge 2
      #2 rst_n = 1'b0;
      #1;
      ntests++;
      if ({busy, pass, fail, fail_guard, overlap, fail_step} !== 30'd0) begin
         nfail++; $display("FAIL reset_mid_async: got %b want 0", {busy, pass, fail, fail_guard, overlap, fail_step});
      end
      ev[0] = 2'b10;
      tick();                                   // edge 3 held in reset
      rst_n = 1'b1;
      tick();
      tick();
      ntests++;
      if (pass[0] !== 1'b0 || fail[0] !== 1'b0 || busy[0] !== 1'b0) begin
         nfail++; $display("FAIL reset_mid_abort: pass=%b fail=%b busy=%b want 0 0 0", pass[0], fail[0], busy[0]);
      end
   endtask

   task automatic test_independent();
      do_reset();
      start = 5'b10111;
      tick();                                   // edge 1
      start = 5'b10000;
      guard = 5'b10101;
      ev[0] = 2'b01; ev[1] = 2'b01; ev[2] = 2'b01; ev[4] = 2'b01;
      tick();                                   // edge 2
      ntests++;
      if (fail !== 5'b00010 || overlap !== 5'b10000 || busy !== 5'b10101 ||
          fail_guard[1] !== 1'b1 || fail_step[1] !== 1'b0) begin
         nfail++; $display("FAIL indep_e2: fail=%b ovl=%b busy=%b fg1=%b fs1=%b want 00010 10000 10101 1 0",
                           fail, overlap, busy, fail_guard[1], fail_step[1]);
      end
      start = 5'b00000;
      ev[0] = 2'b10; ev[1] = 2'b00; ev[2] = 2'b00; ev[4] = 2'b10;
      tick();                                   // edge 3
      ntests++;
      if (pass !== 5'b10001 || fail !== 5'b00100 || busy !== 5'b00000 || overlap !== 5'b00000 ||
          fail_guard[2] !== 1'b0 || fail_step[2] !== 1'b1 || fail_guard[1] !== 1'b1) begin
         nfail++; $display("FAIL indep_e3: pass=%b fail=%b busy=%b ovl=%b fg=%b want 10001 00100 00000 00000 fg2=0 fg1=1",
                           pass, fail, busy, overlap, fail_guard);
      end
`ifdef SEQ_CHK_COUNT_EN
      ntests++;
      if (pass_cnt[0] !== 16'd1 || pass_cnt[4] !== 16'd1 || fail_cnt[1] !== 16'd1 ||
          fail_cnt[2] !== 16'd1 || pass_cnt[3] !== 16'd0 || fail_cnt[3] !== 16'd0 || fail_cnt[0] !== 16'd0) begin
         nfail++; $display("FAIL indep_counters: pass_cnt=%h fail_cnt=%h want p0=1 p4=1 f1=1 f2=1 rest 0",
                           pass_cnt, fail_cnt);
      end
`endif
   endtask

   initial begin
      clear_inputs();
      rst_n = 1'b0;
      test_reset();
      test_pass();
      test_guard_fail();
      test_event_fail();
      test_overlap();
      test_reset_mid();
      test_independent();
      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/seq_throughout_chk.md
SEQ_THROUGHOUT_CHK -- requirements
Module: seq_throughout_chk

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of independent checker channels (1..32).
REQ-002 SHALL have parameter SEQ_LEN, default 2, number of consecutive event steps per sequence (1..16).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  NUM_CH  per-channel trigger (antecedent).
REQ-006 SHALL have port guard  input  NUM_CH  per-channel expression that must hold throughout the sequence.
REQ-007 SHALL have port ev  input  NUM_CH x SEQ_LEN  per-channel step events; ev[c][k] is the event expected at step k.
REQ-008 SHALL have port busy  output  NUM_CH  channel is evaluating a sequence.
REQ-009 SHALL have port pass  output  NUM_CH  one-cycle pulse, sequence matched with guard held.
REQ-010 SHALL have port fail  output  NUM_CH  one-cycle pulse, sequence failed.
REQ-011 SHALL have port fail_step  output  NUM_CH x STEP_W  step index of last failure, STEP_W = max(1, clog2(SEQ_LEN)).
REQ-012 SHALL have port fail_guard  output  NUM_CH  1 = last failure caused by guard low, 0 = by missing event.
REQ-013 SHALL have port overlap  output  NUM_CH  one-cycle pulse, start seen while busy.

Function
REQ-014 Each channel SHALL run an FSM with states IDLE and CHECK plus a step counter 0..SEQ_LEN-1.
REQ-015 IDLE with start[c]=1 at edge T0 SHALL go to CHECK with step=0 (non-overlapping implication: first sample at T0+1).
REQ-016 In CHECK at edge T0+1+k, step k SHALL be evaluated: guard[c]=1 and ev[c][k]=1 required at that same edge.
REQ-017 Guard SHALL be sampled only at sequence sample points; glitches between edges SHALL be ignored.
REQ-018 If guard[c]=0 at a sample point, fail SHALL pulse, fail_guard=1, fail_step=k, FSM to IDLE; guard has priority over event in cause reporting.
REQ-019 If guard[c]=1 and ev[c][k]=0, fail SHALL pulse, fail_guard=0, fail_step=k, FSM to IDLE (early termination).
REQ-020 If both hold and k<SEQ_LEN-1, step SHALL increment; if k=SEQ_LEN-1, pass SHALL pulse and FSM to IDLE.
REQ-021 pass/fail/overlap SHALL be registered, high for exactly the cycle following the evaluating edge; pass and fail SHALL never be high together.
REQ-022 busy SHALL be 1 exactly while in CHECK.
REQ-023 start[c]=1 while in CHECK SHALL be ignored for sequencing and SHALL pulse overlap[c], including on the edge that completes the sequence.
REQ-024 fail_step/fail_guard SHALL hold until the next failure.
REQ-025 Channels SHALL be fully independent; no cross-channel state.

Reset
REQ-026 rst_n low SHALL immediately force all FSMs to IDLE, step=0, and busy, pass, fail, fail_step, fail_guard, overlap to 0, including mid-sequence; no pass/fail is reported for an aborted sequence.
REQ-027 First start sample SHALL be the first rising edge with rst_n high.

Configuration
REQ-028 With SEQ_CHK_COUNT_EN defined, SHALL add outputs pass_cnt and fail_cnt (NUM_CH x 16), incremented on each pass/fail pulse, saturating at 16'hFFFF, reset to 0.
REQ-029 Without SEQ_CHK_COUNT_EN, those ports and counters SHALL not exist.

Structure
REQ-030 Package seq_chk_pkg SHALL hold the FSM state enum (IDLE, CHECK), the STEP_W width function and the counter width constant (16).
REQ-031 Per-channel logic SHALL be a sub-module seq_chk_lane, instantiated NUM_CH times by generate.

Verification
REQ-032 SEQ_LEN=2: start=1 at edge 1; edge 2 guard=1, ev[0]=1; edge 3 guard=1, ev[1]=1 -> pass pulse in cycle after edge 3, busy high cycles 1-2.
REQ-033 Same, guard high from edge 1 to 4 -> pass; guard extra cycles irrelevant.
REQ-034 guard=1 at edge 2 only, ev steps met -> fail after edge 3, fail_guard=1, fail_step=1.
REQ-035 ev[0]=1 at edge 2, ev[1]=0 at edge 3, ev[1]=1 at edge 4 -> fail after edge 3, fail_guard=0, fail_step=1; no pass.
REQ-036 start high edges 1 and 2 -> overlap pulse after edge 2, single sequence evaluated; rst_n low during edge 2..3 -> all outputs 0, no pass/fail.
REQ-037 NUM_CH=5 with distinct stimuli per channel -> per-channel results independent; with SEQ_CHK_COUNT_EN, counters match pulse totals.
